// File: rtl/keccak_pad_tx_if.sv
// Handshake bundle between the message source, the SHA3 pad/lane framer and the
// Keccak permutation input port.
interface keccak_pad_tx_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        in_last;
    logic [3:0]  in_bytes;
    logic        pushout;
    logic        stopout;
    logic        firstout;
    logic        lastout;
    logic [63:0] dout;

    modport master (
        output in_valid, in_data, in_last, in_bytes, stopout,
        input  in_ready, pushout, firstout, lastout, dout
    );

    modport slave (
        input  in_valid, in_data, in_last, in_bytes, stopout,
        output in_ready, pushout, firstout, lastout, dout
    );
endinterface

// File: rtl/keccak_pad_tx.sv
// SHA3 padder and 25-lane block framer feeding the Keccak permutation input port.
// Optional block counter output blk_cnt is enabled by defining KECCAK_PAD_TX_BLKCNT_EN.
module keccak_pad_tx #(
    parameter int         RATE_LANES = 17,
    parameter logic [7:0] DOMAIN     = 8'h06
) (
    input  logic            clk,
    input  logic            rst,
    keccak_pad_tx_if.slave  bus
`ifdef KECCAK_PAD_TX_BLKCNT_EN
    ,
    output logic [15:0]     blk_cnt
`endif
);

    localparam logic [4:0]  LAST_RATE = 5'(RATE_LANES - 1);
    localparam logic [4:0]  LAST_LANE = 5'd24;
    localparam logic [63:0] PAD_END   = 64'h8000_0000_0000_0000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ABSORB,
        S_PAD_NEW,
        S_ZERO_RATE,
        S_CAP
    } state_t;

    state_t      r_state;
    logic [4:0]  r_lane;
    logic        r_pushout;
    logic        r_firstout;
    logic        r_lastout;
    logic [63:0] r_dout;
    logic        r_final;
    logic        r_pad_pend;

    logic        w_adv;
    logic        w_rate_end;
    logic        w_full_last;
    logic [4:0]  w_lane_nxt;
    logic [63:0] w_absorb_lane;

    // Keep the first nb bytes, put the domain byte right after them, clear the rest.
    // nb >= 8 passes the word through untouched.
    function automatic logic [63:0] f_pad_last(input logic [63:0] d, input logic [3:0] nb);
        logic [63:0] r;
        logic [3:0]  n;
        n = (nb > 4'd8) ? 4'd8 : nb;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            if (4'(k) < n) begin
                r[8*k +: 8] = d[8*k +: 8];
            end else if (4'(k) == n) begin
                r[8*k +: 8] = DOMAIN;
            end
        end
        return r;
    endfunction

    assign w_adv       = !r_pushout || !bus.stopout;
    assign w_rate_end  = (r_lane == LAST_RATE);
    assign w_full_last = (bus.in_bytes >= 4'd8);
    assign w_lane_nxt  = (r_lane == LAST_LANE) ? 5'd0 : 5'(r_lane + 5'd1);

    always_comb begin
        w_absorb_lane = f_pad_last(bus.in_data, bus.in_last ? bus.in_bytes : 4'd8);
        if (bus.in_last && !w_full_last && w_rate_end) begin
            w_absorb_lane = w_absorb_lane | PAD_END;
        end
    end

    assign bus.in_ready = (r_state == S_ABSORB) && w_adv;
    assign bus.pushout  = r_pushout;
    assign bus.firstout = r_firstout;
    assign bus.lastout  = r_lastout;
    assign bus.dout     = r_dout;

    // The output register reloads whenever it is empty or its lane is being taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_lane     <= '0;
            r_pushout  <= 1'b0;
            r_firstout <= 1'b0;
            r_lastout  <= 1'b0;
            r_dout     <= '0;
            r_final    <= 1'b0;
            r_pad_pend <= 1'b0;
        end else if (w_adv) begin
            r_pushout  <= 1'b0;
            r_firstout <= 1'b0;
            r_lastout  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_state <= S_ABSORB;
                end
                S_ABSORB: begin
                    if (bus.in_valid) begin
                        r_pushout  <= 1'b1;
                        r_firstout <= (r_lane == 5'd0);
                        r_dout     <= w_absorb_lane;
                        r_lane     <= w_lane_nxt;
                        if (!bus.in_last) begin
                            r_state <= w_rate_end ? S_CAP : S_ABSORB;
                        end else if (w_full_last) begin
                            // A full word in the last rate lane pushes the pad into a fresh block.
                            if (w_rate_end) begin
                                r_state    <= S_CAP;
                                r_pad_pend <= 1'b1;
                            end else begin
                                r_state <= S_PAD_NEW;
                            end
                        end else begin
                            r_final <= 1'b1;
                            r_state <= w_rate_end ? S_CAP : S_ZERO_RATE;
                        end
                    end
                end
                S_PAD_NEW: begin
                    r_pushout  <= 1'b1;
                    r_firstout <= (r_lane == 5'd0);
                    r_dout     <= {56'd0, DOMAIN} | (w_rate_end ? PAD_END : 64'd0);
                    r_lane     <= w_lane_nxt;
                    r_final    <= 1'b1;
                    r_state    <= w_rate_end ? S_CAP : S_ZERO_RATE;
                end
                S_ZERO_RATE: begin
                    r_pushout  <= 1'b1;
                    r_firstout <= (r_lane == 5'd0);
                    r_dout     <= w_rate_end ? PAD_END : 64'd0;
                    r_lane     <= w_lane_nxt;
                    if (w_rate_end) begin
                        r_state <= S_CAP;
                    end
                end
                S_CAP: begin
                    r_pushout  <= 1'b1;
                    r_firstout <= (r_lane == 5'd0);
                    r_lastout  <= r_final && (r_lane == LAST_LANE);
                    r_dout     <= 64'd0;
                    r_lane     <= w_lane_nxt;
                    if (r_lane == LAST_LANE) begin
                        r_final    <= 1'b0;
                        r_pad_pend <= 1'b0;
                        r_state    <= r_pad_pend ? S_PAD_NEW : S_ABSORB;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef KECCAK_PAD_TX_BLKCNT_EN
    logic        r_out_lane24;
    logic [15:0] r_blk_cnt;
    logic        w_xfer;

    assign w_xfer  = r_pushout && !bus.stopout;
    assign blk_cnt = r_blk_cnt;

    // Tracks whether the lane sitting in the output register closes a block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_lane24 <= 1'b0;
        end else if (w_adv) begin
            r_out_lane24 <= (r_lane == LAST_LANE);
        end
    end

    // Counts blocks of the message in flight; the final block's lane restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_blk_cnt <= '0;
        end else if (w_xfer && r_lastout) begin
            r_blk_cnt <= '0;
        end else if (w_xfer && r_out_lane24) begin
            r_blk_cnt <= 16'(r_blk_cnt + 16'd1);
        end
    end
`endif

endmodule

// File: tb/tb_keccak_pad_tx.sv
// Self-checking bench for keccak_pad_tx: byte-level SHA3 pad model against captured lanes.
module tb_keccak_pad_tx;

    localparam int         R   = 17;
    localparam int         RB  = R * 8;
    localparam logic [7:0] DOM = 8'h06;
    localparam int         LIMIT = 3000;

    typedef struct packed {
        logic [63:0] d;
        logic        f;
        logic        l;
    } lane_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    keccak_pad_tx_if bus();
`ifdef KECCAK_PAD_TX_BLKCNT_EN
    logic [15:0] blk_cnt;
`endif

    keccak_pad_tx #(.RATE_LANES(R), .DOMAIN(DOM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef KECCAK_PAD_TX_BLKCNT_EN
        ,
        .blk_cnt (blk_cnt)
`endif
    );

    lane_t cap_q[$];
    lane_t exp_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    bit    done    = 1'b0;
    bit    abort   = 1'b0;

    // A lane visible at the falling edge with stopout low is taken at the next rising edge.
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.pushout === 1'b1 && bus.stopout === 1'b0)
            cap_q.push_back({bus.dout, bus.firstout, bus.lastout});
    end

    // Reference: pad the byte string to a whole number of rate blocks, then slice into lanes.
    function automatic void add_exp(input byte unsigned msg[$]);
        int L, P, nblk;
        byte unsigned pb[];
        lane_t t;
        L = msg.size();
        P = (L / RB + 1) * RB;
        nblk = P / RB;
        pb = new[P];
        for (int i = 0; i < P; i++) pb[i] = (i < L) ? msg[i] : 8'h00;
        pb[L] = DOM;
        pb[P-1] = pb[P-1] | 8'h80;
        for (int b = 0; b < nblk; b++) begin
            for (int ln = 0; ln < 25; ln++) begin
                t.d = 64'd0;
                if (ln < R)
                    for (int k = 0; k < 8; k++) t.d[8*k +: 8] = pb[b*RB + ln*8 + k];
                t.f = (ln == 0);
                t.l = (b == nblk - 1) && (ln == 24);
                exp_q.push_back(t);
            end
        end
    endfunction

    task automatic drive_msg(input byte unsigned msg[$], input int gap_pct);
        int n, nb, budget;
        logic [63:0] d;
        bit acc;
        n = (msg.size() + 7) / 8;
        if (n == 0) n = 1;
        for (int w = 0; w < n && !abort; w++) begin
            d = {$urandom, $urandom};
            for (int k = 0; k < 8; k++)
                if (w*8 + k < msg.size()) d[8*k +: 8] = msg[w*8 + k];
            nb = msg.size() - 8*w;
            while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct && !abort) begin
                bus.in_valid = 1'b0;
                @(posedge clk); #1;
            end
            bus.in_valid = 1'b1;
            bus.in_data  = d;
            bus.in_last  = (w == n - 1);
            if (w != n - 1)      bus.in_bytes = 4'($urandom_range(15));
            else if (nb < 8)     bus.in_bytes = 4'(nb);
            else if (gap_pct > 0) bus.in_bytes = 4'($urandom_range(15, 8));
            else                 bus.in_bytes = 4'd8;
            acc = 1'b0;
            budget = 0;
            while (!acc && !abort) begin
                @(negedge clk);
                acc = (bus.in_ready === 1'b1);
                @(posedge clk); #1;
                budget++;
                if (!acc && budget > LIMIT) begin
                    n_tests++; n_fail++;
                    $display("FAIL drive_timeout word %0d: in_ready stayed 0, required 1", w);
                    abort = 1'b1;
                end
            end
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // Runs messages back to back; stall<0 holds stopout for 5 cycles at lane -stall.
    task automatic run_set(input byte unsigned flat[$], input int lens[$], input int stall,
                           input int gap, input string name);
        int off;
        byte unsigned m[$];
        exp_q.delete();
        cap_q.delete();
        done = 1'b0;
        off = 0;
        foreach (lens[i]) begin
            m.delete();
            for (int j = 0; j < lens[i]; j++) m.push_back(flat[off + j]);
            off += lens[i];
            add_exp(m);
        end
        fork
            begin
                byte unsigned mm[$];
                int o2;
                o2 = 0;
                foreach (lens[i]) begin
                    mm.delete();
                    for (int j = 0; j < lens[i]; j++) mm.push_back(flat[o2 + j]);
                    o2 += lens[i];
                    drive_msg(mm, gap);
                end
            end
            begin
                if (stall >= 0) begin
                    while (!done) begin
                        bus.stopout = (stall > 0) && (int'($urandom_range(99)) < stall);
                        @(posedge clk); #1;
                    end
                end else begin
                    int hl, c;
                    logic [63:0] sd;
                    hl = -stall;
                    bus.stopout = 1'b0;
                    c = 0;
                    while (cap_q.size() < hl && c < LIMIT) begin
                        @(posedge clk); #1;
                        c++;
                    end
                    bus.stopout = 1'b1;
                    sd = '0;
                    for (int s = 0; s < 5; s++) begin
                        @(negedge clk);
                        if (s == 0) begin
                            sd = bus.dout;
                            n_tests++;
                            if (sd !== exp_q[hl].d) begin
                                n_fail++;
                                $display("FAIL %s stall_lane: dout=%h required %h", name, sd, exp_q[hl].d);
                            end
                        end
                        n_tests++;
                        if (bus.pushout !== 1'b1 || bus.dout !== sd || bus.firstout !== exp_q[hl].f
                            || bus.in_ready !== 1'b0) begin
                            n_fail++;
                            $display("FAIL %s stall_hold cyc %0d: push=%b dout=%h first=%b rdy=%b required push=1 dout=%h first=%b rdy=0",
                                     name, s, bus.pushout, bus.dout, bus.firstout, bus.in_ready, sd, exp_q[hl].f);
                        end
                        @(posedge clk); #1;
                    end
                    bus.stopout = 1'b0;
                    while (!done) begin
                        @(posedge clk); #1;
                    end
                end
                bus.stopout = 1'b0;
            end
            begin
                int c;
                c = 0;
                while (cap_q.size() < exp_q.size() && c < LIMIT) begin
                    @(negedge clk);
                    c++;
                end
                repeat (6) @(negedge clk);
                done = 1'b1;
            end
        join
        n_tests++;
        if (cap_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL %s lane_count: got %0d required %0d", name, cap_q.size(), exp_q.size());
        end
        for (int i = 0; i < cap_q.size() && i < exp_q.size(); i++) begin
            n_tests++;
            if (cap_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL %s lane %0d: got d=%h f=%b l=%b required d=%h f=%b l=%b", name, i,
                         cap_q[i].d, cap_q[i].f, cap_q[i].l, exp_q[i].d, exp_q[i].f, exp_q[i].l);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if (bus.pushout !== 1'b0 || bus.firstout !== 1'b0 || bus.lastout !== 1'b0 ||
            bus.dout !== 64'd0 || bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: push=%b first=%b last=%b dout=%h rdy=%b required all 0",
                     bus.pushout, bus.firstout, bus.lastout, bus.dout, bus.in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_ready: in_ready=%b required 0", bus.in_ready);
        end
        @(negedge clk);
        n_tests++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL absorb_ready: in_ready=%b required 1", bus.in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_empty();
        byte unsigned f[$];
        int l[$];
        l.push_back(0);
        run_set(f, l, 0, 0, "empty");
    endtask

    task automatic test_abc();
        byte unsigned f[$];
        int l[$];
        f.push_back(8'h61); f.push_back(8'h62); f.push_back(8'h63);
        l.push_back(3);
        run_set(f, l, 0, 0, "abc");
    endtask

    task automatic test_full17();
        byte unsigned f[$];
        int l[$];
        for (int w = 0; w < 17; w++)
            for (int k = 0; k < 8; k++) f.push_back((k == 0) ? 8'(w) : 8'h00);
        l.push_back(136);
        run_set(f, l, 0, 0, "full17");
    endtask

    task automatic test_short_last();
        byte unsigned f[$];
        int l[$];
        for (int w = 0; w < 16; w++)
            for (int k = 0; k < 8; k++) f.push_back((k == 0) ? 8'(w) : 8'h00);
        for (int k = 0; k < 7; k++) f.push_back(8'hFF);
        l.push_back(135);
        run_set(f, l, 0, 0, "short_last");
    endtask

    task automatic test_stall();
        byte unsigned f[$];
        int l[$];
        f.push_back(8'h61); f.push_back(8'h62); f.push_back(8'h63);
        l.push_back(3);
        run_set(f, l, -3, 0, "stall");
    endtask

    task automatic test_reset_mid();
        byte unsigned m[$];
        byte unsigned f[$];
        int l[$];
        int c;
        for (int i = 0; i < 300; i++) m.push_back(8'($urandom));
        cap_q.delete();
        abort = 1'b0;
        fork
            drive_msg(m, 0);
            begin
                c = 0;
                while (cap_q.size() < 10 && c < LIMIT) begin
                    @(posedge clk); #1;
                    c++;
                end
                #2 rst = 1'b1;
                #1;
                n_tests++;
                if (bus.pushout !== 1'b0 || bus.firstout !== 1'b0 || bus.in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL async_reset: push=%b first=%b rdy=%b required 0 0 0",
                             bus.pushout, bus.firstout, bus.in_ready);
                end
                abort = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
            end
        join
        abort = 1'b0;
        @(posedge clk); #1;
        f.push_back(8'h61); f.push_back(8'h62); f.push_back(8'h63);
        l.push_back(3);
        run_set(f, l, 0, 0, "after_reset");
    endtask

    task automatic test_back_to_back();
        byte unsigned f[$];
        int l[$];
        int n;
        for (int i = 0; i < 3; i++) begin
            n = $urandom_range(200);
            l.push_back(n);
            for (int j = 0; j < n; j++) f.push_back(8'($urandom));
        end
        run_set(f, l, 0, 0, "back_to_back");
    endtask

    task automatic test_random();
        byte unsigned f[$];
        int l[$];
        int n;
        for (int it = 0; it < 12; it++) begin
            f.delete();
            l.delete();
            n = $urandom_range(300);
            l.push_back(n);
            for (int j = 0; j < n; j++) f.push_back(8'($urandom));
            run_set(f, l, 30, 20, $sformatf("random%0d", it));
        end
    endtask

    initial begin
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 64'd0;
        bus.in_last  = 1'b0;
        bus.in_bytes = 4'd0;
        bus.stopout  = 1'b0;
        test_reset();
        test_empty();
        test_abc();
        test_full17();
        test_short_last();
        test_stall();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
